// File: rtl/piso_serializer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : piso_serializer
// Purpose  : Parallel-in, serial-out transmitter with valid/ready load,
//            per-bit valid qualifier, first-bit marker and done pulse.
// Revision : 1.0 - initial release
// ============================================================================
module piso_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             shift_en,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             frame_start,
    output logic             done,
    output logic             busy
);

    localparam int                 c_CNT_W = $clog2(WIDTH + 1);
    localparam logic [c_CNT_W-1:0] c_LOAD  = c_CNT_W'(WIDTH);
    localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_shreg;
    logic [c_CNT_W-1:0] r_count;
    logic               r_first;
    logic               r_done;

    logic [WIDTH-1:0]   w_shreg_next;
    logic               w_out_bit;
    logic               w_busy;

    // The output end of the register is fixed by bit order; bits move toward it.
    generate
        if (MSB_FIRST) begin : g_msb_first
            assign w_shreg_next = {r_shreg[WIDTH-2:0], 1'b0};
            assign w_out_bit    = r_shreg[WIDTH-1];
        end else begin : g_lsb_first
            assign w_shreg_next = {1'b0, r_shreg[WIDTH-1:1]};
            assign w_out_bit    = r_shreg[0];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_shreg <= '0;
            r_count <= '0;
            r_first <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_shreg <= in_data;
                        r_count <= c_LOAD;
                        r_first <= 1'b1;
                        r_state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (shift_en) begin
                        r_shreg <= w_shreg_next;
                        r_count <= r_count - c_ONE;
                        r_first <= 1'b0;
                        // Last bit consumed: free the input side in the done cycle.
                        if (r_count == c_ONE) begin
                            r_state <= S_IDLE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign w_busy      = (r_state == S_SHIFT);
    assign busy        = w_busy;
    assign in_ready    = ~w_busy;
    assign ser_out     = w_busy & w_out_bit;
    assign ser_valid   = w_busy & shift_en;
    assign frame_start = w_busy & shift_en & r_first;
    assign done        = r_done;

endmodule
`default_nettype wire

// File: tb/tb_piso_serializer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_piso_serializer
// Purpose  : Self-checking bench; MSB-first and LSB-first instances, scoreboard
//            of expected serial bits plus handshake/done/busy checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_piso_serializer;

    typedef struct packed {
        logic b;
        logic first;
    } exp_t;

    typedef struct {
        int         d;
        logic [7:0] data;
        bit         stall;
        logic [7:0] bits;   // expected bits in emission order, [7] first
        int         cyc;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] in_valid_s;
    logic [7:0] in_data;
    logic       shift_en;
    logic [1:0] in_ready_s, ser_out_s, ser_valid_s, frame_start_s, done_s, busy_s;

    int   checks = 0;
    int   errors = 0;
    int   a      = 0;
    exp_t sb[$];
    vec_t tv[3];

    always #5 clk = ~clk;

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .reset(reset), .in_valid(in_valid_s[0]), .in_ready(in_ready_s[0]),
        .in_data(in_data), .shift_en(shift_en), .ser_out(ser_out_s[0]),
        .ser_valid(ser_valid_s[0]), .frame_start(frame_start_s[0]),
        .done(done_s[0]), .busy(busy_s[0])
    );

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .reset(reset), .in_valid(in_valid_s[1]), .in_ready(in_ready_s[1]),
        .in_data(in_data), .shift_en(shift_en), .ser_out(ser_out_s[1]),
        .ser_valid(ser_valid_s[1]), .frame_start(frame_start_s[1]),
        .done(done_s[1]), .busy(busy_s[1])
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (dut %0d, t=%0t): got %0h, expected %0h", nm, a, $time, act, exp);
        end
    endtask

    // Scoreboard monitor: every qualified bit must match the next expected bit.
    task automatic mon();
        exp_t e;
        chk("other_dut_valid", ser_valid_s[1-a], 1'b0);
        if (ser_valid_s[a]) begin
            if (sb.size() == 0) begin
                chk("unexpected_bit", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("ser_out", ser_out_s[a], e.b);
                chk("frame_start", frame_start_s[a], e.first);
            end
        end else begin
            chk("frame_start_nobit", frame_start_s[a], 1'b0);
        end
    endtask

    task automatic settle();
        #1;
        mon();
    endtask

    task automatic adv();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic push_bits(input logic [7:0] bits);
        exp_t e;
        for (int i = 0; i < 8; i++) begin
            e.b     = bits[7-i];
            e.first = (i == 0);
            sb.push_back(e);
        end
    endtask

    task automatic run_frame(input int d, input logic [7:0] data, input bit stall,
                             input logic [7:0] bits, input int cyc, input int poke,
                             input bit exp_done);
        int n;
        int sent;
        a          = d;
        in_valid_s = '0;
        in_valid_s[d] = 1'b1;
        in_data    = data;
        shift_en   = 1'b1;
        settle();
        chk("load_ready", in_ready_s[d], 1'b1);
        chk("load_done", done_s[d], exp_done);
        chk("load_ser_valid", ser_valid_s[d], 1'b0);
        push_bits(bits);
        adv();
        n    = 0;
        sent = 0;
        while (sent < 8 && n < 40) begin
            shift_en   = stall ? (n % 2 == 0) : 1'b1;
            in_valid_s = '0;
            if (n == poke) begin
                in_valid_s[d] = 1'b1;
                in_data       = 8'hFF;
            end
            settle();
            chk("busy", busy_s[d], 1'b1);
            chk("ready_low", in_ready_s[d], 1'b0);
            chk("done_low", done_s[d], 1'b0);
            if (!shift_en) begin
                chk("stall_valid", ser_valid_s[d], 1'b0);
                if (sb.size() > 0) chk("stall_hold", ser_out_s[d], sb[0].b);
            end else begin
                sent++;
            end
            n++;
            adv();
        end
        in_valid_s = '0;
        chk("frame_cycles", n, cyc);
    endtask

    task automatic done_idle(input int d);
        a          = d;
        in_valid_s = '0;
        shift_en   = 1'b1;
        settle();
        chk("done_pulse", done_s[d], 1'b1);
        chk("done_busy", busy_s[d], 1'b0);
        chk("done_ready", in_ready_s[d], 1'b1);
        chk("done_ser_valid", ser_valid_s[d], 1'b0);
        chk("done_ser_out", ser_out_s[d], 1'b0);
        chk("sb_drained", sb.size(), 0);
        adv();
        settle();
        chk("done_one_cycle", done_s[d], 1'b0);
        adv();
    endtask

    initial begin
        tv[0] = '{d: 0, data: 8'hAA, stall: 1'b0, bits: 8'b1010_1010, cyc: 8};
        tv[1] = '{d: 0, data: 8'h55, stall: 1'b1, bits: 8'b0101_0101, cyc: 15};
        tv[2] = '{d: 1, data: 8'hB4, stall: 1'b1, bits: 8'b0010_1101, cyc: 15};

        reset      = 1'b1;
        in_valid_s = '0;
        in_data    = 8'h00;
        shift_en   = 1'b1;
        @(negedge clk);
        adv();
        adv();
        reset = 1'b0;
        settle();
        for (int d = 0; d < 2; d++) begin
            chk("rst_ready", in_ready_s[d], 1'b1);
            chk("rst_busy", busy_s[d], 1'b0);
            chk("rst_ser_out", ser_out_s[d], 1'b0);
            chk("rst_ser_valid", ser_valid_s[d], 1'b0);
            chk("rst_done", done_s[d], 1'b0);
        end
        adv();

        for (int i = 0; i < 3; i++) begin
            run_frame(tv[i].d, tv[i].data, tv[i].stall, tv[i].bits, tv[i].cyc, -1, 1'b0);
            done_idle(tv[i].d);
        end

        // Load attempt while shifting must be ignored.
        run_frame(0, 8'hC3, 1'b0, 8'b1100_0011, 8, 3, 1'b0);
        done_idle(0);

        // Reset after three bits aborts the frame with no done pulse.
        a             = 0;
        in_valid_s[0] = 1'b1;
        in_data       = 8'hC3;
        shift_en      = 1'b1;
        settle();
        chk("abort_load_ready", in_ready_s[0], 1'b1);
        push_bits(8'b1100_0011);
        adv();
        in_valid_s = '0;
        for (int i = 0; i < 3; i++) begin
            settle();
            adv();
        end
        reset    = 1'b1;
        shift_en = 1'b0;
        settle();
        adv();
        reset = 1'b0;
        sb.delete();
        settle();
        chk("abort_busy", busy_s[0], 1'b0);
        chk("abort_ready", in_ready_s[0], 1'b1);
        chk("abort_done", done_s[0], 1'b0);
        chk("abort_ser_out", ser_out_s[0], 1'b0);
        adv();
        settle();
        chk("abort_no_late_done", done_s[0], 1'b0);
        adv();
        run_frame(0, 8'h0F, 1'b0, 8'b0000_1111, 8, -1, 1'b0);
        done_idle(0);

        // LSB-first back-to-back: second word accepted in the done cycle.
        run_frame(1, 8'h01, 1'b0, 8'b1000_0000, 8, -1, 1'b0);
        run_frame(1, 8'h80, 1'b0, 8'b0000_0001, 8, -1, 1'b1);
        done_idle(1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
